// File: rtl/iir_filter_mc.sv
// Multi-channel, time-interleaved 2nd-order IIR with runtime tap signs and per-channel history.
// Optional output saturation is enabled by defining IIR_FILTER_MC_SAT_EN (default: two's-complement wrap).
module iir_filter_mc #(
  parameter int NB_DATA = 8,
  parameter int N_CH    = 2,
  parameter int SH1     = 1,
  parameter int SH2     = 2
) (
  input  logic                             clock,
  input  logic                             i_rst,
  input  logic signed [NB_DATA-1:0]        i_x,
  input  logic                             i_valid,
  input  logic                             i_clear,
  input  logic [3:0]                       i_tap_sign,
  output logic signed [NB_DATA-1:0]        o_y,
  output logic                             o_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_ch
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned AW = NB_DATA + 3;

  // Per-channel history: three past inputs and two past outputs.
  logic signed [NB_DATA-1:0] xh1 [N_CH];
  logic signed [NB_DATA-1:0] xh2 [N_CH];
  logic signed [NB_DATA-1:0] xh3 [N_CH];
  logic signed [NB_DATA-1:0] yh1 [N_CH];
  logic signed [NB_DATA-1:0] yh2 [N_CH];

  logic [CW-1:0]             ptr;
  logic [CW-1:0]             ptr_next;
  logic                      accept;
  logic signed [NB_DATA-1:0] x1_sel;
  logic signed [NB_DATA-1:0] x2_sel;
  logic signed [NB_DATA-1:0] x3_sel;
  logic signed [NB_DATA-1:0] y1_sel;
  logic signed [NB_DATA-1:0] y2_sel;
  logic signed [AW-1:0]      acc;
  logic signed [NB_DATA-1:0] y_next;

  // Sign-extend a sample to accumulator width and optionally negate it.
  function automatic logic signed [AW-1:0] signed_tap(input logic signed [NB_DATA-1:0] x,
                                                      input logic neg);
    logic signed [AW-1:0] ext;
    ext = AW'(x);
    return neg ? -ext : ext;
  endfunction

  assign accept = i_valid && !i_clear;

  // History of the channel currently addressed by the pointer.
  always_comb begin
    x1_sel = xh1[ptr];
    x2_sel = xh2[ptr];
    x3_sel = xh3[ptr];
    y1_sel = yh1[ptr];
    y2_sel = yh2[ptr];
  end

  // Pointer advances per accepted sample and wraps at the last channel.
  always_comb begin
    ptr_next = ptr;
    if (N_CH == 1) begin
      ptr_next = '0;
    end else if (ptr == CW'(N_CH - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = ptr + CW'(1);
    end
  end

  // Full-precision sum; feedback terms are shifted at storage width before extension.
  always_comb begin
    acc = signed_tap(i_x,    i_tap_sign[0])
        + signed_tap(x1_sel, i_tap_sign[1])
        + signed_tap(x2_sel, i_tap_sign[2])
        + signed_tap(x3_sel, i_tap_sign[3])
        + AW'(y1_sel >>> SH1)
        + AW'(y2_sel >>> SH2);
  end

`ifdef IIR_FILTER_MC_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (NB_DATA - 1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN = -Y_MAX - AW'(1);

  always_comb begin
    y_next = NB_DATA'(acc);
    if (acc > Y_MAX) begin
      y_next = NB_DATA'(Y_MAX);
    end else if (acc < Y_MIN) begin
      y_next = NB_DATA'(Y_MIN);
    end
  end
`else
  always_comb begin
    y_next = NB_DATA'(acc);
  end
`endif

  // Output register; clear drops a coincident sample and leaves o_y/o_ch holding.
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      o_y     <= '0;
      o_valid <= 1'b0;
      o_ch    <= '0;
    end else begin
      o_valid <= accept;
      if (accept) begin
        o_y  <= y_next;
        o_ch <= ptr;
      end
    end
  end

  // Pointer and history state; only the addressed channel shifts on a sample.
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
      for (int i = 0; i < N_CH; i++) begin
        xh1[i] <= '0;
        xh2[i] <= '0;
        xh3[i] <= '0;
        yh1[i] <= '0;
        yh2[i] <= '0;
      end
    end else if (i_clear) begin
      ptr <= '0;
      for (int i = 0; i < N_CH; i++) begin
        xh1[i] <= '0;
        xh2[i] <= '0;
        xh3[i] <= '0;
        yh1[i] <= '0;
        yh2[i] <= '0;
      end
    end else if (i_valid) begin
      ptr      <= ptr_next;
      xh3[ptr] <= x2_sel;
      xh2[ptr] <= x1_sel;
      xh1[ptr] <= i_x;
      yh2[ptr] <= y1_sel;
      yh1[ptr] <= y_next;
    end
  end

endmodule

// File: tb/tb_iir_filter_mc.sv
// Directed bench for iir_filter_mc: one single-channel and one dual-channel instance on shared stimulus.
module tb_iir_filter_mc;

  logic              clock;
  logic              i_rst;
  logic signed [7:0] i_x;
  logic              i_valid;
  logic              i_clear;
  logic [3:0]        i_tap_sign;

  logic signed [7:0] y1;
  logic              v1;
  logic              c1;
  logic signed [7:0] y2;
  logic              v2;
  logic              c2;

  int tests = 0;
  int fails = 0;

  iir_filter_mc #(.NB_DATA(8), .N_CH(1), .SH1(1), .SH2(2)) u_one (
    .clock(clock), .i_rst(i_rst), .i_x(i_x), .i_valid(i_valid), .i_clear(i_clear),
    .i_tap_sign(i_tap_sign), .o_y(y1), .o_valid(v1), .o_ch(c1)
  );

  iir_filter_mc #(.NB_DATA(8), .N_CH(2), .SH1(1), .SH2(2)) u_two (
    .clock(clock), .i_rst(i_rst), .i_x(i_x), .i_valid(i_valid), .i_clear(i_clear),
    .i_tap_sign(i_tap_sign), .o_y(y2), .o_valid(v2), .o_ch(c2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic apply(input int x, input logic v, input logic c, input logic [3:0] tap);
    @(negedge clock);
    i_x        = 8'(x);
    i_valid    = v;
    i_clear    = c;
    i_tap_sign = tap;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_rst   = 1'b1;
    @(negedge clock);
    i_rst   = 1'b0;
  endtask

  int gx  [6] = '{1, 2, 3, 4, 1, 2};
  int gy  [6] = '{1, 1, 2, 5, 4, 11};
  int ix  [5] = '{1, 0, 2, 0, 3};
  int iy  [5] = '{1, 0, 1, 0, 2};
  int ich [5] = '{0, 1, 0, 1, 0};
  int ovf2;

  initial begin
    i_rst = 1'b1; i_x = '0; i_valid = 1'b0; i_clear = 1'b0; i_tap_sign = '0;
    #12;
    chk("reset_y1", y1, 0);
    chk("reset_v1", v1, 0);
    chk("reset_y2", y2, 0);
    chk("reset_v2", v2, 0);
    chk("reset_c2", c2, 0);
    @(negedge clock);
    i_rst = 1'b0;

    // Golden sequence, single channel
    for (int i = 0; i < 6; i++) begin
      apply(gx[i], 1'b1, 1'b0, 4'b0010);
      chk($sformatf("golden_y[%0d]", i), y1, gy[i]);
      chk($sformatf("golden_v[%0d]", i), v1, 1);
    end
    apply(0, 1'b0, 1'b0, 4'b0010);
    chk("golden_idle_v", v1, 0);
    chk("golden_idle_y", y1, 11);

    // Channel interleave, two channels
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(ix[i], 1'b1, 1'b0, 4'b0010);
      chk($sformatf("ilv_y[%0d]", i), y2, iy[i]);
      chk($sformatf("ilv_ch[%0d]", i), c2, ich[i]);
      chk($sformatf("ilv_v[%0d]", i), v2, 1);
    end

    // Overflow: 127 + 127 + 63 = 317
`ifdef IIR_FILTER_MC_SAT_EN
    ovf2 = 127;
`else
    ovf2 = 61;
`endif
    do_reset();
    apply(127, 1'b1, 1'b0, 4'b0000);
    chk("ovf_y0", y1, 127);
    apply(127, 1'b1, 1'b0, 4'b0000);
    chk("ovf_y1", y1, ovf2);

    // Negative path: -8 + (-4 >>> 1)
    do_reset();
    apply(-4, 1'b1, 1'b0, 4'b0000);
    chk("neg_y0", y1, -4);
    apply(-4, 1'b1, 1'b0, 4'b0000);
    chk("neg_y1", y1, -10);

    // Clear and gaps
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(gx[i], 1'b1, 1'b0, 4'b0010);
      chk($sformatf("clr_pre_y[%0d]", i), y1, gy[i]);
    end
    apply(0, 1'b0, 1'b0, 4'b0010);
    chk("gap0_v", v1, 0);
    chk("gap0_y", y1, 2);
    apply(0, 1'b0, 1'b0, 4'b0010);
    chk("gap1_v", v1, 0);
    chk("gap1_y", y1, 2);
    apply(9, 1'b1, 1'b1, 4'b0010);
    chk("clr_drop_v", v1, 0);
    chk("clr_drop_y", y1, 2);
    apply(1, 1'b1, 1'b0, 4'b0010);
    chk("clr_post_y0", y1, 1);
    chk("clr_post_c0", c1, 0);
    apply(2, 1'b1, 1'b0, 4'b0010);
    chk("clr_post_y1", y1, 1);
    chk("clr_post_v1", v1, 1);

    // Async reset mid-stream, two channels
    do_reset();
    apply(3, 1'b1, 1'b0, 4'b0000);
    chk("ar_y0", y2, 3);
    apply(5, 1'b1, 1'b0, 4'b0000);
    chk("ar_y1", y2, 5);
    chk("ar_c1", c2, 1);
    apply(2, 1'b1, 1'b0, 4'b0000);
    chk("ar_y2", y2, 6);
    i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    chk("ar_async_y", y2, 0);
    chk("ar_async_v", v2, 0);
    chk("ar_async_c", c2, 0);
    @(negedge clock);
    i_rst = 1'b0;
    apply(5, 1'b1, 1'b0, 4'b0000);
    chk("ar_post_y", y2, 5);
    chk("ar_post_c", c2, 0);
    chk("ar_post_v", v2, 1);

    apply(0, 1'b0, 1'b0, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iir_filter_mc.md
Name: iir_filter_mc

Overview:
- Parametrised successor of the team's fixed 8-bit 2nd-order IIR: y[n] = Σk s_k·x[n-k] (k=0..3) + (y[n-1] >>> SH1) + (y[n-2] >>> SH2).
- New versus the fixed filter:
  - per-sample runtime tap signs
  - configurable shift amounts
  - valid-qualified input
  - N_CH time-interleaved channels, each with its own history
  - synchronous history clear
- Sits between sample source and downstream DSP.

Parameters:
- NB_DATA, 8, signed sample/output width (≥4).
- N_CH, 2, number of interleaved channels (≥1).
- SH1, 1, arithmetic right shift applied to y[n-1].
- SH2, 2, arithmetic right shift applied to y[n-2].

Ports:
- clock  in  1  rising-edge clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_x  in  NB_DATA  signed input sample.
- i_valid  in  1  i_x is a sample for the current channel this cycle.
- i_clear  in  1  synchronous clear of all histories and channel pointer.
- i_tap_sign  in  4  bit k=1 → s_k=-1, else +1, for x[n-k]; sampled with i_valid.
- o_y  out  NB_DATA  signed filtered output, registered.
- o_valid  out  1  one-cycle strobe, o_y/o_ch valid.
- o_ch  out  max(1,clog2(N_CH))  channel index of o_y.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - o_y=0, o_valid=0, o_ch=0, channel pointer=0.
  - All per-channel x[n-1..n-3] and y[n-1..n-2] registers = 0.
- Channel pointer:
  - Internal counter selects the channel for each accepted sample.
  - Increments by 1 on each accepted sample; wraps N_CH-1 → 0.
  - N_CH=1 → always 0.
- Accepted sample (i_valid=1, i_clear=0):
  - Compute from i_x and the selected channel's stored history.
  - Accumulator width NB_DATA+3, signed, full precision; no intermediate overflow possible.
  - Shifts are arithmetic (floor toward −∞), applied to stored NB_DATA y values before the add.
  - Result reduced to NB_DATA (see Optional Feature) and registered to o_y.
  - Next edge: o_valid=1 and o_ch=pointer used. Latency 1 cycle.
- History update on the same edge, selected channel only:
  - x[n-3]←x[n-2], x[n-2]←x[n-1], x[n-1]←i_x.
  - y[n-2]←y[n-1], y[n-1]←reduced output.
  - Other channels untouched.
- i_valid=0: no history or pointer change; o_valid=0; o_y and o_ch hold last value.
- Back-to-back samples on the same channel (N_CH=1, i_valid held high): each output uses the previous output. No bubbles required, full throughput of 1 sample/cycle.
- i_clear=1:
  - All histories → 0 and pointer → 0 at the edge.
  - A coincident i_valid sample is dropped: o_valid=0, o_y holds.
  - Clear has priority over valid.
- Reset asserted mid-stream: immediate clear of all state and outputs; the first sample after release goes to channel 0 with zero history.
- i_tap_sign may change on any sample; it affects only that sample's computation.

Optional Feature:
- Macro: IIR_FILTER_MC_SAT_EN.
- Defined: accumulator saturates to [-2^(NB_DATA-1), 2^(NB_DATA-1)-1]. The saturated value is both output and stored as y history.
- Undefined: keep the low NB_DATA bits (two's-complement wrap). The wrapped value is output and stored.

Test Plan:
- Golden sequence: N_CH=1, NB_DATA=8, i_tap_sign=4'b0010, defaults SH1=1, SH2=2, reset then i_x=1,2,3,4,1,2 on consecutive valid cycles → o_y=1,1,2,5,4,11, each 1 cycle after its input, o_valid high 6 cycles.
- Channel interleave: N_CH=2, i_tap_sign=0010, valid stream ch0=1, ch1=0, ch0=2, ch1=0, ch0=3 → ch0 outputs 1,1,2 and ch1 outputs 0,0; o_ch alternates 0,1,0,1,0.
- Overflow: N_CH=1, i_tap_sign=0, i_x=127 held for 2 samples.
  - Macro defined → o_y=127,127.
  - Macro undefined → o_y=127,61.
- Clear and gaps: run the golden sequence for 3 samples, then 2 idle cycles (o_y holds 2, o_valid=0), then i_clear=1 together with i_valid=1 and i_x=9 (dropped, o_valid=0), then i_x=1,2 → o_y=1,1 on channel 0.
- Async reset mid-stream: N_CH=2, assert i_rst between clock edges after 3 samples → o_y, o_valid and o_ch go to 0 without waiting for a clock edge; after release, i_x=5 with i_tap_sign=0 → o_y=5, o_ch=0.
- Negative/sign path: N_CH=1, i_tap_sign=0, i_x=-4,-4 → o_y=-4, -10 (-8 + (-4>>>1 = -2)).
